// File: rtl/int_xing_pkg.sv
// Shared types and limits for the synchronous interrupt crossing.
package int_xing_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } int_edge_state_e;

  localparam int INT_MAX_LINES = 32;

endpackage

// File: rtl/int_edge_capture.sv
// One edge-captured interrupt line: rising edge sets a sticky pending bit
// that holds until acked, with a saturating count of edges merged into it.
module int_edge_capture
  import int_xing_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in,
  input  logic             ack,
  input  logic             clr,
  output logic             pend,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  int_edge_state_e  state_q, state_d;
  logic             in_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;
  logic             inc;

  assign rise = in & ~in_q;
  // A fresh edge that lands together with an ack replaces the consumed event,
  // so only an un-acked edge on a pending line counts as coalesced.
  assign inc  = (state_q == PEND) & rise & ~ack;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = PEND;
      PEND:    if (ack && !rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      in_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in;
      cnt_q   <= cnt_d;
    end
  end

  assign pend = (state_q == PEND);
  assign cnt  = cnt_q;

endmodule

// File: rtl/int_sync_crossing_source.sv
// Source end of the synchronous interrupt crossing: level lines are retimed
// by one flop, edge lines go through a per-line pending/coalesce capture.
module int_sync_crossing_source
  import int_xing_pkg::*;
#(
  parameter int               N_INT     = 2,
  parameter logic [N_INT-1:0] EDGE_MASK = '0,
  parameter int               CNT_W     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_INT-1:0]       auto_in,
  output logic [N_INT-1:0]       auto_out_sync,
  input  logic [N_INT-1:0]       auto_out_ack,
  output logic [N_INT*CNT_W-1:0] coalesce_cnt,
  input  logic                   coalesce_clr
);

  if (N_INT < 1 || N_INT > INT_MAX_LINES) begin : g_bad_n_int
    $error("int_sync_crossing_source: N_INT out of range");
  end

  for (genvar i = 0; i < N_INT; i++) begin : g_line
    if (EDGE_MASK[i]) begin : g_edge
      logic             pend;
      logic [CNT_W-1:0] cnt;

      int_edge_capture #(
        .CNT_W (CNT_W)
      ) u_cap (
        .clock (clock),
        .reset (reset),
        .in    (auto_in[i]),
        .ack   (auto_out_ack[i]),
        .clr   (coalesce_clr),
        .pend  (pend),
        .cnt   (cnt)
      );

      assign auto_out_sync[i]                = pend;
      assign coalesce_cnt[i*CNT_W +: CNT_W]  = cnt;
    end else begin : g_level
      logic lvl_q;
      // Ack and clear have no meaning on a level line.
      logic unused_lvl;
      assign unused_lvl = auto_out_ack[i] ^ coalesce_clr;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          lvl_q <= 1'b0;
        end else begin
          lvl_q <= auto_in[i];
        end
      end

      assign auto_out_sync[i]               = lvl_q;
      assign coalesce_cnt[i*CNT_W +: CNT_W] = '0;
    end
  end

endmodule

// File: tb/tb_int_sync_crossing_source.sv
// Directed bench: one level + one edge line (CNT_W=4) and a single edge line
// with CNT_W=2 for saturation.
module tb_int_sync_crossing_source;

  logic       clock;
  logic       reset;
  logic [1:0] auto_in;
  logic [1:0] ack;
  logic       clr;
  logic [1:0] sync_a;
  logic [7:0] cnt_a;

  logic [0:0] in_b;
  logic [0:0] ack_b;
  logic       clr_b;
  logic [0:0] sync_b;
  logic [1:0] cnt_b;

  int n_vec = 0;
  int n_err = 0;

  int_sync_crossing_source #(
    .N_INT     (2),
    .EDGE_MASK (2'b10),
    .CNT_W     (4)
  ) dut_a (
    .clock         (clock),
    .reset         (reset),
    .auto_in       (auto_in),
    .auto_out_sync (sync_a),
    .auto_out_ack  (ack),
    .coalesce_cnt  (cnt_a),
    .coalesce_clr  (clr)
  );

  int_sync_crossing_source #(
    .N_INT     (1),
    .EDGE_MASK (1'b1),
    .CNT_W     (2)
  ) dut_b (
    .clock         (clock),
    .reset         (reset),
    .auto_in       (in_b),
    .auto_out_sync (sync_b),
    .auto_out_ack  (ack_b),
    .coalesce_cnt  (cnt_b),
    .coalesce_clr  (clr_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    auto_in = 2'b11;
    ack     = 2'b00;
    clr     = 1'b0;
    in_b    = 1'b1;
    ack_b   = 1'b0;
    clr_b   = 1'b0;

    // Reset held with inputs high
    repeat (2) tick();
    check_vec("rst_sync_a", 32'(sync_a), 32'h0);
    check_vec("rst_cnt_a",  32'(cnt_a),  32'h0);
    check_vec("rst_sync_b", 32'(sync_b), 32'h0);

    reset = 1'b1;
    tick();
    check_vec("rel_sync_a", 32'(sync_a), 32'h3);
    check_vec("rel_sync_b", 32'(sync_b), 32'h1);

    // Ack edge line while input still high: no re-trigger
    ack = 2'b10;
    tick();
    check_vec("ack_clears", 32'(sync_a), 32'h1);
    ack = 2'b00;
    tick();
    check_vec("no_retrig", 32'(sync_a), 32'h1);

    // Level line follows with one cycle latency; ack ignored
    auto_in[0] = 1'b0;
    tick();
    check_vec("lvl_low", 32'(sync_a[0]), 32'h0);
    auto_in[0] = 1'b1;
    ack = 2'b01;
    tick();
    check_vec("lvl_high_ack", 32'(sync_a[0]), 32'h1);
    ack = 2'b00;
    auto_in[0] = 1'b0;
    tick();
    check_vec("lvl_fall", 32'(sync_a[0]), 32'h0);

    // New edge on line1
    auto_in = 2'b00;
    tick();
    check_vec("idle_line1", 32'(sync_a[1]), 32'h0);
    auto_in[1] = 1'b1;
    tick();
    check_vec("edge_pend", 32'(sync_a[1]), 32'h1);
    repeat (2) tick();
    check_vec("edge_hold", 32'(sync_a[1]), 32'h1);
    check_vec("cnt_hold0", 32'(cnt_a[7:4]), 32'h0);

    // Three coalesced pulses
    for (int k = 0; k < 3; k++) begin
      auto_in[1] = 1'b0;
      tick();
      auto_in[1] = 1'b1;
      tick();
    end
    check_vec("coal_cnt3",  32'(cnt_a[7:4]), 32'h3);
    check_vec("coal_pend",  32'(sync_a[1]),  32'h1);
    check_vec("lvl_cnt0",   32'(cnt_a[3:0]), 32'h0);

    // Ack and rise together: stays pending, count unchanged
    auto_in[1] = 1'b0;
    tick();
    auto_in[1] = 1'b1;
    ack = 2'b10;
    tick();
    ack = 2'b00;
    check_vec("coll_pend", 32'(sync_a[1]),  32'h1);
    check_vec("coll_cnt",  32'(cnt_a[7:4]), 32'h3);

    // Clear with rise together: clear wins
    auto_in[1] = 1'b0;
    tick();
    auto_in[1] = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_vec("clr_wins", 32'(cnt_a[7:4]), 32'h0);
    check_vec("clr_pend", 32'(sync_a[1]),  32'h1);
    auto_in[1] = 1'b0;
    tick();
    auto_in[1] = 1'b1;
    tick();
    check_vec("post_clr_inc", 32'(cnt_a[7:4]), 32'h1);

    // Saturation with CNT_W=2: five pulses stop at 3
    for (int k = 0; k < 5; k++) begin
      in_b = 1'b0;
      tick();
      in_b = 1'b1;
      tick();
      if (k == 1) check_vec("sat_cnt2", 32'(cnt_b), 32'h2);
    end
    check_vec("sat_cnt", 32'(cnt_b),  32'h3);
    check_vec("sat_pend", 32'(sync_b), 32'h1);

    // Async reset between clock edges
    #2;
    reset = 1'b0;
    #1;
    check_vec("arst_sync_a", 32'(sync_a), 32'h0);
    check_vec("arst_cnt_a",  32'(cnt_a),  32'h0);
    check_vec("arst_sync_b", 32'(sync_b), 32'h0);
    check_vec("arst_cnt_b",  32'(cnt_b),  32'h0);

    // Input high across deassertion is seen as a rising edge
    auto_in = 2'b10;
    tick();
    reset = 1'b1;
    tick();
    check_vec("rearm_sync_a", 32'(sync_a), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
